idli_sqi_mem_m: RTL and testbench

// SQI (quad SPI) memory responder: the far end of the core's SQI controller link.

---
 rtl/idli_sqi_mem_m.sv | 190 +++++++++++++++++++
 tb/tb_idli_sqi_mem_m.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m
// SQI (quad SPI) memory responder. Sits at the far end of the core's SQI
// controller link and stands in for the external SQI SRAM. It decodes a
// READ (0x03) or WRITE (0x02) command, a 24-bit address and, for reads, one
// dummy byte, then streams nibbles from or into a local byte array.
// SCK is treated as a gck-synchronous data signal and edge-detected against
// a single registered copy. Inputs are sampled on SCK rise and outputs are
// updated on SCK fall.

module idli_sqi_mem_m #(
    parameter int  MEM_BYTES = 256,
    localparam int ADDR_W    = $clog2(MEM_BYTES)
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sqi_data,
    output logic [3:0] o_mem_sqi_data,
    output logic       o_mem_sqi_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RD,
        S_WR,
        S_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Protocol state
    state_t            state_reg;
    logic              sck_q_reg;
    logic [2:0]        cnt_reg;       // nibble counter within CMD/ADDR/DUMMY
    logic              is_wr_reg;     // decoded command: 1 = write frame
    logic              phase_reg;     // 0 = high nibble next, 1 = low nibble next
    logic [3:0]        nib_hold_reg;  // command high nibble / write high nibble
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        data_reg;
    logic              oe_reg;

    // Storage
    logic [7:0]        mem [MEM_BYTES];
    logic [7:0]        rd_byte_reg;

    // Edge detect and datapath helpers
    logic              rise;
    logic              fall;
    logic              wr_en;
    logic [7:0]        wr_byte;
    logic [ADDR_W-1:0] addr_shift;
    logic [ADDR_W-1:0] addr_inc;

    assign rise = i_mem_sck & ~sck_q_reg;
    assign fall = ~i_mem_sck & sck_q_reg;

    // Shifting every address nibble in and keeping only the low bits is the
    // same as truncating the full 24-bit address at the end.
    assign addr_shift = ADDR_W'({addr_reg, i_mem_sqi_data});
    assign addr_inc   = addr_reg + ADDR_W'(1);

    // A byte is committed on the second rise of each write pair.
    assign wr_en   = ~i_mem_cs && (state_reg == S_WR) && rise && phase_reg;
    assign wr_byte = {nib_hold_reg, i_mem_sqi_data};

    assign o_mem_sqi_data = data_reg;
    assign o_mem_sqi_oe   = oe_reg;

    // Protocol FSM: command/address/dummy decode, read nibble output, write pairing.
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_reg    <= S_IDLE;
            sck_q_reg    <= 1'b0;
            cnt_reg      <= 3'd0;
            is_wr_reg    <= 1'b0;
            phase_reg    <= 1'b0;
            nib_hold_reg <= 4'h0;
            addr_reg     <= '0;
            data_reg     <= 4'h0;
            oe_reg       <= 1'b0;
        end else begin
            sck_q_reg <= i_mem_sck;
            if (i_mem_cs) begin
                // Deselected: abandon the frame, including any half-written byte.
                state_reg <= S_IDLE;
                oe_reg    <= 1'b0;
                cnt_reg   <= 3'd0;
                phase_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (rise) begin
                            nib_hold_reg <= i_mem_sqi_data;
                            cnt_reg      <= 3'd1;
                            state_reg    <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (rise) begin
                            cnt_reg <= 3'd0;
                            if ({nib_hold_reg, i_mem_sqi_data} == CMD_READ) begin
                                is_wr_reg <= 1'b0;
                                state_reg <= S_ADDR;
                            end else if ({nib_hold_reg, i_mem_sqi_data} == CMD_WRITE) begin
                                is_wr_reg <= 1'b1;
                                state_reg <= S_ADDR;
                            end else begin
                                state_reg <= S_IGNORE;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (rise) begin
                            addr_reg <= addr_shift;
                            if (cnt_reg == 3'd5) begin
                                cnt_reg   <= 3'd0;
                                phase_reg <= 1'b0;
                                state_reg <= is_wr_reg ? S_WR : S_DUMMY;
                            end else begin
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (rise) begin
                            if (cnt_reg == 3'd1) begin
                                cnt_reg   <= 3'd0;
                                phase_reg <= 1'b0;
                                state_reg <= S_RD;
                            end else begin
                                cnt_reg <= cnt_reg + 3'd1;
                            end
                        end
                    end
                    S_RD: begin
                        // rd_byte_reg has at least one gck to settle after an
                        // address step because SCK high lasts >= 1 gck.
                        if (fall) begin
                            oe_reg <= 1'b1;
                            if (!phase_reg) begin
                                data_reg  <= rd_byte_reg[7:4];
                                phase_reg <= 1'b1;
                            end else begin
                                data_reg  <= rd_byte_reg[3:0];
                                phase_reg <= 1'b0;
                                addr_reg  <= addr_inc;
                            end
                        end
                    end
                    S_WR: begin
                        if (rise) begin
                            if (!phase_reg) begin
                                nib_hold_reg <= i_mem_sqi_data;
                                phase_reg    <= 1'b1;
                            end else begin
                                phase_reg <= 1'b0;
                                addr_reg  <= addr_inc;
                            end
                        end
                    end
                    S_IGNORE: begin
                        oe_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        oe_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Storage write port: one byte per completed write pair.
    always_ff @(posedge i_mem_gck) begin
        if (wr_en) begin
            mem[addr_reg] <= wr_byte;
        end
    end

    // Registered read port, continuously following the current address.
    always_ff @(posedge i_mem_gck) begin
        rd_byte_reg <= mem[addr_reg];
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Testbench for idli_sqi_mem_m: drives SQI frames as the controller would
// and checks returned nibbles and output-enable against a byte-array model.

module tb_idli_sqi_mem_m;

    localparam int MEM_BYTES = 256;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       cs;
    logic [3:0] din;
    logic [3:0] dout;
    logic       oe;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_model [MEM_BYTES];
    logic [3:0] tx_data [$];
    logic [3:0] rx_nib  [$];
    logic       rx_oe   [$];
    logic       post_oe;

    always #5 clk = ~clk;

    idli_sqi_mem_m #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_mem_gck      (clk),
        .i_mem_rst_n    (rst_n),
        .i_mem_sck      (sck),
        .i_mem_cs       (cs),
        .i_mem_sqi_data (din),
        .o_mem_sqi_data (dout),
        .o_mem_sqi_oe   (oe)
    );

    // Model: bytes written land at (addr mod MEM_BYTES) + i, wrapping.
    function automatic void model_write(input logic [23:0] a, input int n_nib);
        int base;
        base = int'(a) % MEM_BYTES;
        for (int i = 0; i < n_nib / 2; i++)
            mem_model[(base + i) % MEM_BYTES] = {tx_data[2*i], tx_data[2*i+1]};
    endfunction

    // Model: k-th nibble of a read stream starting at a (high nibble first).
    function automatic logic [3:0] exp_nib(input logic [23:0] a, input int k);
        int         base;
        logic [7:0] b;
        base = int'(a) % MEM_BYTES;
        b    = mem_model[(base + k / 2) % MEM_BYTES];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    // One SCK period: present nibble, low phase, sample responder, high phase.
    task automatic sck_pulse(input logic [3:0] nib, output logic [3:0] rd, output logic o);
        din = nib;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rd  = dout;
        o   = oe;
        sck = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        sck = 1'b0;
    endtask

    // Full cs frame: cmd, 6 address nibbles, dummy byte for READ, n_data data pulses.
    task automatic do_frame(input logic [7:0] cmd, input logic [23:0] addr, input int n_data);
        logic [3:0] seq [$];
        logic [3:0] r;
        logic       o;
        rx_nib.delete();
        rx_oe.delete();
        seq.push_back(cmd[7:4]);
        seq.push_back(cmd[3:0]);
        for (int i = 5; i >= 0; i--) seq.push_back(addr[i*4 +: 4]);
        if (cmd == 8'h03) begin
            seq.push_back(4'($urandom));
            seq.push_back(4'($urandom));
        end
        while (tx_data.size() < n_data) tx_data.push_back(4'($urandom));
        for (int i = 0; i < n_data; i++) seq.push_back(tx_data[i]);
        @(negedge clk);
        cs = 1'b0;
        foreach (seq[i]) begin
            sck_pulse(seq[i], r, o);
            rx_nib.push_back(r);
            rx_oe.push_back(o);
        end
        @(negedge clk);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        post_oe = oe;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cs    = 1'b1;
        sck   = 1'b0;
        din   = 4'h0;
        repeat (3) @(negedge clk);
        total++;
        if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", oe); end
        total++;
        if (dout !== 4'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dout); end
        rst_n = 1'b1;
        // SCK activity with cs high must be ignored.
        repeat (4) begin
            @(negedge clk) sck = 1'b1;
            @(negedge clk) sck = 1'b0;
        end
        repeat (2) @(negedge clk);
        total++;
        if (oe !== 1'b0) begin bad++; $display("FAIL idle_oe got=%b exp=0", oe); end
        total++;
        if (dout !== 4'h0) begin bad++; $display("FAIL idle_data got=%h exp=0", dout); end
        $display("test_reset done");
    endtask

    task automatic test_fill;
        logic [23:0] a;
        a = 24'($urandom);
        tx_data.delete();
        do_frame(8'h02, a, 2 * MEM_BYTES);
        model_write(a, 2 * MEM_BYTES);
        for (int i = 0; i < rx_oe.size(); i++) begin
            total++;
            if (rx_oe[i] !== 1'b0) begin bad++; $display("FAIL fill_wr_oe pulse=%0d got=%b exp=0", i, rx_oe[i]); end
        end
        a = 24'($urandom);
        tx_data.delete();
        do_frame(8'h03, a, 2 * MEM_BYTES);
        for (int i = 0; i < rx_oe.size(); i++) begin
            total++;
            if (rx_oe[i] !== (i >= 10)) begin bad++; $display("FAIL fill_rd_oe pulse=%0d got=%b exp=%b", i, rx_oe[i], i >= 10); end
            if (i >= 10) begin
                total++;
                if (rx_nib[i] !== exp_nib(a, i - 10))
                    begin bad++; $display("FAIL fill_rd_data k=%0d got=%h exp=%h", i - 10, rx_nib[i], exp_nib(a, i - 10)); end
            end
        end
        total++;
        if (post_oe !== 1'b0) begin bad++; $display("FAIL fill_post_oe got=%b exp=0", post_oe); end
        $display("test_fill base=%h done", a);
    endtask

    task automatic test_write_read;
        logic [3:0] want [$];
        want = '{4'hA, 4'h5, 4'h3, 4'hC};
        tx_data = '{4'hA, 4'h5, 4'h3, 4'hC};
        do_frame(8'h02, 24'h000010, 4);
        model_write(24'h000010, 4);
        for (int i = 0; i < rx_oe.size(); i++) begin
            total++;
            if (rx_oe[i] !== 1'b0) begin bad++; $display("FAIL wr_oe pulse=%0d got=%b exp=0", i, rx_oe[i]); end
        end
        tx_data.delete();
        do_frame(8'h03, 24'h000010, 4);
        for (int i = 0; i < rx_oe.size(); i++) begin
            total++;
            if (rx_oe[i] !== (i >= 10)) begin bad++; $display("FAIL rd_oe pulse=%0d got=%b exp=%b", i, rx_oe[i], i >= 10); end
            if (i >= 10) begin
                total++;
                if (rx_nib[i] !== want[i-10]) begin bad++; $display("FAIL rd_data k=%0d got=%h exp=%h", i - 10, rx_nib[i], want[i-10]); end
            end
        end
        total++;
        if (post_oe !== 1'b0) begin bad++; $display("FAIL rd_post_oe got=%b exp=0", post_oe); end
        $display("test_write_read done");
    endtask

    task automatic test_wrap;
        logic [3:0] want [$];
        want = '{4'h1, 4'h1, 4'h2, 4'h2};
        tx_data = '{4'h1, 4'h1, 4'h2, 4'h2};
        do_frame(8'h02, 24'(MEM_BYTES - 1), 4);
        model_write(24'(MEM_BYTES - 1), 4);
        tx_data.delete();
        do_frame(8'h03, 24'(MEM_BYTES - 1), 4);
        for (int i = 10; i < rx_nib.size(); i++) begin
            total++;
            if (rx_nib[i] !== want[i-10]) begin bad++; $display("FAIL wrap_rd k=%0d got=%h exp=%h", i - 10, rx_nib[i], want[i-10]); end
        end
        do_frame(8'h03, 24'h000000, 2);
        for (int i = 10; i < rx_nib.size(); i++) begin
            total++;
            if (rx_nib[i] !== 4'h2) begin bad++; $display("FAIL wrap_byte0 k=%0d got=%h exp=2", i - 10, rx_nib[i]); end
        end
        $display("test_wrap done");
    endtask

    task automatic test_unknown_cmd;
        logic [3:0] want [$];
        want = '{4'hA, 4'h5, 4'h3, 4'hC};
        tx_data = '{4'h9, 4'h6};
        do_frame(8'h05, 24'h000010, 2);
        for (int i = 0; i < rx_oe.size(); i++) begin
            total++;
            if (rx_oe[i] !== 1'b0) begin bad++; $display("FAIL unk_oe pulse=%0d got=%b exp=0", i, rx_oe[i]); end
        end
        tx_data.delete();
        do_frame(8'h03, 24'h000010, 4);
        for (int i = 10; i < rx_nib.size(); i++) begin
            total++;
            if (rx_nib[i] !== want[i-10]) begin bad++; $display("FAIL unk_mem k=%0d got=%h exp=%h", i - 10, rx_nib[i], want[i-10]); end
        end
        $display("test_unknown_cmd done");
    endtask

    task automatic test_partial_write;
        // Full byte A5 then a lone high nibble 7: only A5 commits.
        tx_data = '{4'hA, 4'h5, 4'h7};
        do_frame(8'h02, 24'h000040, 3);
        model_write(24'h000040, 3);
        // Lone high nibble at the same address: discarded at cs high.
        tx_data = '{4'h7};
        do_frame(8'h02, 24'h000040, 1);
        tx_data.delete();
        do_frame(8'h03, 24'h000040, 4);
        total++;
        if ({rx_nib[10], rx_nib[11]} !== 8'hA5)
            begin bad++; $display("FAIL partial_keep got=%h exp=a5", {rx_nib[10], rx_nib[11]}); end
        total++;
        if ({rx_nib[12], rx_nib[13]} !== mem_model[8'h41])
            begin bad++; $display("FAIL partial_next got=%h exp=%h", {rx_nib[12], rx_nib[13]}, mem_model[8'h41]); end
        $display("test_partial_write done");
    endtask

    task automatic test_addr_upper;
        logic [7:0] b;
        b = 8'($urandom);
        tx_data = '{b[7:4], b[3:0]};
        do_frame(8'h02, 24'hFFFF20, 2);
        model_write(24'hFFFF20, 2);
        tx_data.delete();
        do_frame(8'h03, 24'h000020, 2);
        total++;
        if ({rx_nib[10], rx_nib[11]} !== b) begin bad++; $display("FAIL upper_low got=%h exp=%h", {rx_nib[10], rx_nib[11]}, b); end
        do_frame(8'h03, 24'h123420, 2);
        total++;
        if ({rx_nib[10], rx_nib[11]} !== b) begin bad++; $display("FAIL upper_alias got=%h exp=%h", {rx_nib[10], rx_nib[11]}, b); end
        $display("test_addr_upper byte=%h done", b);
    endtask

    task automatic test_random;
        logic [23:0] a;
        logic [7:0]  c;
        int          kind;
        int          nb;
        int          n;
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 4);
            a    = 24'($urandom);
            nb   = $urandom_range(1, 6);
            tx_data.delete();
            if (kind <= 1) begin
                n = 2 * nb + $urandom_range(0, 1);
                do_frame(8'h02, a, n);
                model_write(a, n);
                for (int i = 0; i < rx_oe.size(); i++) begin
                    total++;
                    if (rx_oe[i] !== 1'b0) begin bad++; $display("FAIL rand_wr_oe t=%0d pulse=%0d got=%b exp=0", t, i, rx_oe[i]); end
                end
                $display("rand t=%0d WRITE addr=%h nibbles=%0d", t, a, n);
            end else if (kind <= 3) begin
                do_frame(8'h03, a, 2 * nb);
                for (int i = 0; i < rx_oe.size(); i++) begin
                    total++;
                    if (rx_oe[i] !== (i >= 10)) begin bad++; $display("FAIL rand_rd_oe t=%0d pulse=%0d got=%b exp=%b", t, i, rx_oe[i], i >= 10); end
                    if (i >= 10) begin
                        total++;
                        if (rx_nib[i] !== exp_nib(a, i - 10))
                            begin bad++; $display("FAIL rand_rd_data t=%0d k=%0d got=%h exp=%h", t, i - 10, rx_nib[i], exp_nib(a, i - 10)); end
                    end
                end
                $display("rand t=%0d READ addr=%h bytes=%0d", t, a, nb);
            end else begin
                c = 8'($urandom);
                while (c == 8'h02 || c == 8'h03) c = 8'($urandom);
                do_frame(c, a, 2 * nb);
                for (int i = 0; i < rx_oe.size(); i++) begin
                    total++;
                    if (rx_oe[i] !== 1'b0) begin bad++; $display("FAIL rand_unk_oe t=%0d pulse=%0d got=%b exp=0", t, i, rx_oe[i]); end
                end
                $display("rand t=%0d CMD=%h addr=%h ignored", t, c, a);
            end
            total++;
            if (post_oe !== 1'b0) begin bad++; $display("FAIL rand_post_oe t=%0d got=%b exp=0", t, post_oe); end
        end
        // Sweep the whole array against the model after the random traffic.
        tx_data.delete();
        do_frame(8'h03, 24'h000000, 2 * MEM_BYTES);
        for (int i = 10; i < rx_nib.size(); i++) begin
            total++;
            if (rx_nib[i] !== exp_nib(24'h000000, i - 10))
                begin bad++; $display("FAIL rand_sweep k=%0d got=%h exp=%h", i - 10, rx_nib[i], exp_nib(24'h000000, i - 10)); end
        end
        $display("test_random done");
    endtask

    task automatic test_reset_mid_rd;
        logic [3:0] seq [$];
        logic [3:0] r;
        logic       o;
        tx_data = '{4'hA, 4'h5};
        do_frame(8'h02, 24'h000033, 2);
        model_write(24'h000033, 2);
        // Start a READ of 0x33 and stop partway through the data phase.
        seq = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        @(negedge clk);
        cs = 1'b0;
        foreach (seq[i]) sck_pulse(seq[i], r, o);
        @(negedge clk);
        total++;
        if (oe !== 1'b1) begin bad++; $display("FAIL mid_rd_oe got=%b exp=1", oe); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (oe !== 1'b0) begin bad++; $display("FAIL mid_rst_oe got=%b exp=0", oe); end
        total++;
        if (dout !== 4'h0) begin bad++; $display("FAIL mid_rst_data got=%h exp=0", dout); end
        cs  = 1'b1;
        sck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (oe !== 1'b0) begin bad++; $display("FAIL post_rst_oe got=%b exp=0", oe); end
        tx_data.delete();
        do_frame(8'h03, 24'h000033, 2);
        for (int i = 0; i < rx_oe.size(); i++) begin
            total++;
            if (rx_oe[i] !== (i >= 10)) begin bad++; $display("FAIL post_rst_rd_oe pulse=%0d got=%b exp=%b", i, rx_oe[i], i >= 10); end
        end
        total++;
        if ({rx_nib[10], rx_nib[11]} !== 8'hA5)
            begin bad++; $display("FAIL post_rst_rd got=%h exp=a5", {rx_nib[10], rx_nib[11]}); end
        $display("test_reset_mid_rd done");
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_read();
        test_wrap();
        test_unknown_cmd();
        test_partial_write();
        test_addr_upper();
        test_random();
        test_reset_mid_rd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
